// File: rtl/sram_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sram_controller                                               |
// | Purpose  : Sequencer between the cache controller and a 16-bit           |
// |            asynchronous SRAM. A line fill is four 16-bit read beats      |
// |            assembled little-endian into a 64-bit line. A write-through   |
// |            store is two 16-bit write beats. Completion is signalled by   |
// |            a one-cycle ready pulse.                                      |
// | Ports    : clk, rst (async, active high)                                 |
// |            address[15:0]   32-bit-word address from the cache            |
// |            mem_read        line-fill request (level, sampled in IDLE)    |
// |            mem_write       word-write request (level, wins over read)    |
// |            write_data[31:0] store data                                   |
// |            read_data[63:0] assembled line (registered)                   |
// |            ready           one-cycle completion pulse                    |
// |            SRAM_ADDR[17:0] halfword address                              |
// |            SRAM_DQ[15:0]   bidirectional data, driven only while writing |
// |            SRAM_WE_N, SRAM_OE_N active-low strobes                       |
// |            SRAM_CE_N, SRAM_UB_N, SRAM_LB_N tied low                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sram_controller #(
  parameter int BEAT_CYCLES = 1  // cycles each SRAM beat is held, 1..7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] write_data,
  output logic [63:0] read_data,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] WCNT_LAST = 3'(BEAT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  beat_q,  beat_d;
  logic [2:0]  wcnt_q,  wcnt_d;
  logic [15:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;

  logic        beat_end;
  logic [15:0] dq_out;

  assign beat_end = (wcnt_q == WCNT_LAST);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= 2'd0;
      wcnt_q  <= 3'd0;
      addr_q  <= 16'd0;
      wdata_q <= 32'd0;
      rdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        beat_d = 2'd0;
        wcnt_d = 3'd0;
        // Write has priority when both requests are present.
        if (mem_write) begin
          addr_d  = address;
          wdata_d = write_data;
          state_d = ST_WRITE;
        end else if (mem_read) begin
          addr_d  = address;
          state_d = ST_READ;
        end
      end

      ST_READ: begin
        if (beat_end) begin
          // Sample on the last cycle of the beat so the asynchronous SRAM
          // has had the full beat to settle.
          rdata_d[{beat_q, 4'b0000} +: 16] = SRAM_DQ;
          wcnt_d = 3'd0;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d = ST_DONE;
          end
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end

      ST_WRITE: begin
        if (beat_end) begin
          wcnt_d = 3'd0;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd1) begin
            state_d = ST_DONE;
          end
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs: all decoded from registered state
  // ---------------------------------------------------------------------
  always_comb begin
    SRAM_ADDR = 18'd0;
    case (state_q)
      ST_READ:  SRAM_ADDR = {1'b0, addr_q[15:1], 2'b00} + {16'd0, beat_q};
      ST_WRITE: SRAM_ADDR = {1'b0, addr_q, 1'b0} + {16'd0, beat_q};
      default:  SRAM_ADDR = 18'd0;
    endcase
  end

  assign dq_out    = beat_q[0] ? wdata_q[31:16] : wdata_q[15:0];
  assign SRAM_DQ   = (state_q == ST_WRITE) ? dq_out : 16'hzzzz;

  assign SRAM_OE_N = (state_q != ST_READ);
  assign SRAM_WE_N = (state_q != ST_WRITE);
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  assign ready     = (state_q == ST_DONE);
  assign read_data = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sram_controller                                            |
// | Purpose  : Directed self-checking bench for sram_controller, with a      |
// |            BEAT_CYCLES=1 instance on a small SRAM model and a            |
// |            BEAT_CYCLES=3 instance on an address-pattern read model.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_sram_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int          n_cmp;
  int          n_err;

  // ---------------- BEAT_CYCLES = 1 instance ----------------
  logic [15:0] address;
  logic        mem_read, mem_write;
  logic [31:0] write_data;
  logic [63:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        we_n, oe_n, ce_n, ub_n, lb_n;
  logic        probe_en;
  logic [15:0] mem [0:63];

  sram_controller #(.BEAT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .address(address), .mem_read(mem_read),
    .mem_write(mem_write), .write_data(write_data), .read_data(read_data),
    .ready(ready), .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq),
    .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  // SRAM model: drives on read, optional probe value while idle to show
  // that the controller has released the bus.
  assign sram_dq = (!oe_n && we_n) ? mem[sram_addr[5:0]] :
                   (probe_en ? 16'h5A5A : 16'hzzzz);

  // Reset preloads halfword i with {4{i%4+1}}: 0x20..0x23 = 1111..4444.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= {4{4'(i % 4 + 1)}};
    end else if (!we_n) begin
      mem[sram_addr[5:0]] <= sram_dq;
    end
  end

  // ---------------- BEAT_CYCLES = 3 instance ----------------
  logic [15:0] address3;
  logic        mem_read3, mem_write3;
  logic [31:0] write_data3;
  logic [63:0] read_data3;
  logic        ready3;
  logic [17:0] sram_addr3;
  wire  [15:0] sram_dq3;
  logic        we3_n, oe3_n, ce3_n, ub3_n, lb3_n;

  sram_controller #(.BEAT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .address(address3), .mem_read(mem_read3),
    .mem_write(mem_write3), .write_data(write_data3), .read_data(read_data3),
    .ready(ready3), .SRAM_ADDR(sram_addr3), .SRAM_DQ(sram_dq3),
    .SRAM_WE_N(we3_n), .SRAM_OE_N(oe3_n), .SRAM_CE_N(ce3_n),
    .SRAM_UB_N(ub3_n), .SRAM_LB_N(lb3_n)
  );

  assign sram_dq3 = (!oe3_n && we3_n) ? (sram_addr3[15:0] ^ 16'hA000) : 16'hzzzz;

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read of word address a: expects halfwords base..base+3 and line exp.
  task automatic do_read(input logic [15:0] a, input logic [17:0] base,
                         input logic [63:0] exp);
    address  = a;
    mem_read = 1'b1;
    tick();                       // sample edge
    mem_read = 1'b0;
    for (int b = 0; b < 4; b++) begin
      chk("rd_addr", 64'(sram_addr), 64'(base) + 64'(b));
      chk("rd_oe_n", 64'(oe_n), 64'd0);
      chk("rd_ready_early", 64'(ready), 64'd0);
      tick();
    end
    chk("rd_ready", 64'(ready), 64'd1);
    chk("rd_data", read_data, exp);
    tick();
    chk("rd_ready_drop", 64'(ready), 64'd0);
  endtask

  // Write of word address a; both=1 also raises mem_read.
  task automatic do_write(input logic [15:0] a, input logic [31:0] wd,
                          input logic both);
    int we_cnt;
    we_cnt     = 0;
    address    = a;
    write_data = wd;
    mem_write  = 1'b1;
    mem_read   = both;
    tick();
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    chk("wr_addr0", 64'(sram_addr), 64'({1'b0, a, 1'b0}));
    chk("wr_dq0", 64'(sram_dq), 64'(wd[15:0]));
    if (!we_n) we_cnt++;
    tick();
    chk("wr_addr1", 64'(sram_addr), 64'({1'b0, a, 1'b0}) + 64'd1);
    chk("wr_dq1", 64'(sram_dq), 64'(wd[31:16]));
    if (!we_n) we_cnt++;
    tick();
    if (!we_n) we_cnt++;
    chk("wr_ready", 64'(ready), 64'd1);
    chk("wr_we_cycles", 64'(we_cnt), 64'd2);
    tick();
    chk("wr_ready_drop", 64'(ready), 64'd0);
    chk("wr_mem_lo", 64'(mem[6'({a, 1'b0})]), 64'(wd[15:0]));
    chk("wr_mem_hi", 64'(mem[6'({a, 1'b0}) + 6'd1]), 64'(wd[31:16]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst         = 1'b1;
    probe_en    = 1'b0;
    address     = 16'd0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    write_data  = 32'd0;
    address3    = 16'd0;
    mem_read3   = 1'b0;
    mem_write3  = 1'b0;
    write_data3 = 32'd0;

    tick();
    tick();
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_we_n", 64'(we_n), 64'd1);
    chk("rst_oe_n", 64'(oe_n), 64'd1);
    chk("rst_addr", 64'(sram_addr), 64'd0);
    chk("rst_rdata", read_data, 64'd0);
    rst = 1'b0;

    // Idle: no ready, bus released.
    probe_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_ready", 64'(ready), 64'd0);
      chk("idle_dq_released", 64'(sram_dq), 64'h5A5A);
    end
    probe_en = 1'b0;

    // Line fill.
    do_read(16'h0010, 18'h00020, 64'h4444_3333_2222_1111);

    // Write then read-back.
    do_write(16'h0011, 32'hDEAD_BEEF, 1'b0);
    do_read(16'h0010, 18'h00020, 64'hDEAD_BEEF_2222_1111);

    // Both requests: write wins, read_data untouched.
    do_write(16'h0012, 32'hCAFE_F00D, 1'b1);
    chk("both_rdata_kept", read_data, 64'hDEAD_BEEF_2222_1111);

    // Request held across ready: one idle cycle, then a new transaction.
    address    = 16'h0013;
    write_data = 32'h1234_5678;
    mem_write  = 1'b1;
    tick();
    tick();
    tick();
    chk("hold_ready1", 64'(ready), 64'd1);
    tick();
    chk("hold_idle_ready", 64'(ready), 64'd0);
    chk("hold_idle_we_n", 64'(we_n), 64'd1);
    tick();
    chk("hold_restart_we_n", 64'(we_n), 64'd0);
    chk("hold_restart_addr", 64'(sram_addr), 64'h26);
    mem_write = 1'b0;
    tick();
    tick();
    chk("hold_ready2", 64'(ready), 64'd1);
    tick();

    // Reset during read beat 2.
    address  = 16'h0010;
    mem_read = 1'b1;
    tick();
    mem_read = 1'b0;
    tick();
    tick();
    chk("mid_beat2_addr", 64'(sram_addr), 64'h22);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_rdata", read_data, 64'd0);
    chk("mid_rst_oe_n", 64'(oe_n), 64'd1);
    chk("mid_rst_addr", 64'(sram_addr), 64'd0);
    chk("mid_rst_ready", 64'(ready), 64'd0);
    tick();
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (ready) seen++;
      end
      chk("mid_rst_no_ready", 64'(seen), 64'd0);
    end
    do_read(16'h0010, 18'h00020, 64'h4444_3333_2222_1111);

    // BEAT_CYCLES = 3 read at the top of the address space.
    address3  = 16'hFFFF;
    mem_read3 = 1'b1;
    tick();
    mem_read3 = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < 3; c++) begin
        chk("b3_addr", 64'(sram_addr3), 64'h1FFFC + 64'(b));
        chk("b3_ready_early", 64'(ready3), 64'd0);
        tick();
      end
    end
    chk("b3_ready", 64'(ready3), 64'd1);
    chk("b3_data", read_data3, 64'h5FFF_5FFE_5FFD_5FFC);
    tick();
    chk("b3_ready_drop", 64'(ready3), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
